i2c_codec_responder: RTL
========================

# i2c_codec_responder

I2C target model of the audio codec's 2-wire control port. Oversamples `I2C_SCLK`/`I2C_SDAT` on the system clock, decodes 3-byte codec write frames (device address, 7-bit register address + data MSB, data LSBs), ACKs them and stores the 9-bit values in an internal register file. Sits on the bench side opposite the codec initiator in `exp3`, replacing the fixed every-9th-bit ACK stub so configuration sequences are checked by content rather than timing alone.

## Interface
- `DEV_ADDR`, 7'h1A: 7-bit device address; write byte 0x34.
- `NUM_REGS`, 16: register file depth; register addresses ≥ `NUM_REGS` are NACKed.
- `RESET_REG`, 7'h0F: address whose write clears the register file.
- `clk`  in  1  system clock (50 MHz in the top level).
- `reset`  in  1  asynchronous, active-low reset.
- `i2c_sclk`  in  1  SCL as seen on the bus.
- `i2c_sdat_in`  in  1  SDA as seen on the bus.
- `i2c_sdat_oe`  out  1  1 = pull SDA low (ACK); 0 = release (top ties SDA to `oe ? 0 : z`).
- `reg_wr_valid`  out  1  one-cycle pulse when a full frame is committed.
- `reg_wr_addr`  out  7  register address of the committed frame.
- `reg_wr_data`  out  9  data of the committed frame.
- `rd_addr`  in  4  register file read index.
- `rd_data`  out  9  registered read of `rd_addr` (1-cycle latency).
- `busy`  out  1  high between START and STOP.
- `frame_err`  out  1  sticky; set on any aborted/NACKed frame, cleared only by reset.

## Operation
- Inputs pass a 2-flop synchronizer, then edge detect on synchronized SCL.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both honoured in every state; repeated START restarts at ADDR.
- Bits sampled on SCL rising edge, MSB first; bit counter 0..7.
- FSM: IDLE → (START) ADDR → ACK_A → BYTE_HI → ACK_H → BYTE_LO → ACK_L → DONE; IGNORE on any NACK.
- ADDR: 8 bits; ACK only if bits[7:1] == `DEV_ADDR` and bit0 == 0. Otherwise no ACK, go IGNORE, set `frame_err` (address mismatch does not set it).
- BYTE_HI: reg_addr = bits[7:1], data[8] = bit0. NACK + IGNORE + `frame_err` if reg_addr ≥ `NUM_REGS` and ≠ `RESET_REG`.
- BYTE_LO: data[7:0]. ACK_L always ACKs.
- Commit on the SCL falling edge ending ACK_L: file[reg_addr] ← data, `reg_wr_valid` pulse, `reg_wr_addr/data` held until next commit. Write to `RESET_REG` clears all entries to 0 instead (pulse still issued).
- DONE: further bytes NACKed, `frame_err` set; wait STOP/START.
- STOP/START before commit: frame discarded, no write, `frame_err` set (unless in IDLE/DONE/IGNORE after mismatch).
- ACK drive: `i2c_sdat_oe` set on the SCL falling edge ending bit 7, cleared on the next SCL falling edge; never driven outside ACK slots.

## Timing
- Reset: all outputs 0, file all 0, FSM IDLE; async reset releases SDA immediately.
- Input-to-detect latency: 3 `clk` (2 sync + edge reg); `oe` changes 1 `clk` after detected SCL fall.
- Commit pulse 1 `clk` after detected SCL fall ending ACK_L.
- Bus requirement: SCL high and low phases ≥ 8 `clk`; SDA stable ≥ 4 `clk` around SCL rise.
- `busy` rises 1 `clk` after START detect, falls 1 `clk` after STOP detect.

## Configuration
- `I2C_RESP_GLITCH_FILTER_EN` defined: 3-sample majority filter after the synchronizer on SCL and SDA; pulses ≤ 1 `clk` rejected; detect latency becomes 5 `clk`, bus phase minimum 10 `clk`.
- Undefined: no filter; latency 3 `clk`; single-cycle glitches act as edges.

## Test plan
- Frame 0x34, 0x08, 0x15 + STOP → three ACKs, pulse with addr 4 data 0x015, `rd_addr`=4 → `rd_data`=0x015, `frame_err`=0.
- Frame 0x36, … → no ACK on any bit slot, no pulse, `frame_err`=0, file unchanged.
- Frame 0x35 → NACK on address, IGNORE, `frame_err`=1.
- Frame 0x34, 0x0D then STOP → ACK twice, no pulse, `frame_err`=1; then 0x34, 0x1E, 0x00 → file all 0, pulse addr 0x0F.
- Frame 0x34, 0x0A, 0xFF then repeated START 0x34, 0x0C, 0x01 → pulses (5,0x0FF) then (6,0x001).
- Assert `reset` during ACK_H with `oe`=1 → `oe` 0 same instant, FSM IDLE, partial frame not written.

Source files
------------

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C target model of the codec control port; decodes 3-byte frames into a register file.
// Optional feature macro: I2C_RESP_GLITCH_FILTER_EN (3-sample majority filter on SCL/SDA after the synchronizer).
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 16,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    output logic       reg_wr_valid,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic       frame_err,
    output logic [3:0] state_dbg
);

    localparam int         AW         = $clog2(NUM_REGS);
    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR    = 4'd1,
        S_ACK_A   = 4'd2,
        S_BYTE_HI = 4'd3,
        S_ACK_H   = 4'd4,
        S_BYTE_LO = 4'd5,
        S_ACK_L   = 4'd6,
        S_DONE    = 4'd7,
        S_IGNORE  = 4'd8
    } state_t;

    state_t     state;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_f;
    logic       sda_f;
    logic       scl_q;
    logic       sda_q;
    logic [7:0] shreg;
    logic [3:0] bit_cnt;
    logic [6:0] reg_addr;
    logic       data_hi;
    logic [7:0] data_lo;
    logic [8:0] file_q [NUM_REGS];

    // Synchronizer flops reset to the idle-bus level so reset release never fakes a START/STOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i2c_sclk};
            sda_sync <= {sda_sync[0], i2c_sdat_in};
        end
    end

`ifdef I2C_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic shifting;
    logic mid_frame;

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign shifting  = state inside {S_ADDR, S_BYTE_HI, S_BYTE_LO, S_DONE};
    // A START/STOP anywhere between address and commit throws a frame away.
    assign mid_frame = state inside {S_ADDR, S_ACK_A, S_BYTE_HI, S_ACK_H, S_BYTE_LO, S_ACK_L};
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            reg_addr     <= '0;
            data_hi      <= 1'b0;
            data_lo      <= '0;
            i2c_sdat_oe  <= 1'b0;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) file_q[i] <= '0;
        end else begin
            reg_wr_valid <= 1'b0;
            if (start_det) begin
                if (mid_frame) frame_err <= 1'b1;
                state       <= S_ADDR;
                bit_cnt     <= '0;
                i2c_sdat_oe <= 1'b0;
                busy        <= 1'b1;
            end else if (stop_det) begin
                if (mid_frame) frame_err <= 1'b1;
                state       <= S_IDLE;
                bit_cnt     <= '0;
                i2c_sdat_oe <= 1'b0;
                busy        <= 1'b0;
            end else if (scl_rise) begin
                if (shifting && bit_cnt != 4'd8) begin
                    shreg   <= {shreg[6:0], sda_f};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (scl_fall) begin
                // Byte states act on the fall ending bit 0; ACK states act on the fall ending the ACK slot.
                case (state)
                    S_ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                                i2c_sdat_oe <= 1'b1;
                                state       <= S_ACK_A;
                            end else begin
                                if (shreg[7:1] == DEV_ADDR) frame_err <= 1'b1;
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_ACK_A: begin
                        i2c_sdat_oe <= 1'b0;
                        state       <= S_BYTE_HI;
                    end
                    S_BYTE_HI: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt  <= '0;
                            reg_addr <= shreg[7:1];
                            data_hi  <= shreg[0];
                            if (shreg[7:1] < NUM_REGS_W || shreg[7:1] == RESET_REG) begin
                                i2c_sdat_oe <= 1'b1;
                                state       <= S_ACK_H;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_IGNORE;
                            end
                        end
                    end
                    S_ACK_H: begin
                        i2c_sdat_oe <= 1'b0;
                        state       <= S_BYTE_LO;
                    end
                    S_BYTE_LO: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt     <= '0;
                            data_lo     <= shreg;
                            i2c_sdat_oe <= 1'b1;
                            state       <= S_ACK_L;
                        end
                    end
                    S_ACK_L: begin
                        i2c_sdat_oe  <= 1'b0;
                        state        <= S_DONE;
                        reg_wr_valid <= 1'b1;
                        reg_wr_addr  <= reg_addr;
                        reg_wr_data  <= {data_hi, data_lo};
                        if (reg_addr == RESET_REG) begin
                            for (int i = 0; i < NUM_REGS; i++) file_q[i] <= '0;
                        end else begin
                            file_q[reg_addr[AW-1:0]] <= {data_hi, data_lo};
                        end
                    end
                    S_DONE: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt   <= '0;
                            frame_err <= 1'b1;
                            state     <= S_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= file_q[rd_addr];
    end

endmodule
